uart_tx: RTL and testbench

//  Serial transmitter for the memory-mapped UART TX register; drains the byte strobe from mem onto the board TX pin.
//  - Buffers bytes in a FIFO and serialises each as 8N1: start bit 0, 8 data bits LSB first, stop bit 1.
//  - Sits between mem (uart_tx_data / uart_tx_wen) and the top-level RS-232 pin.

---
 rtl/uart_tx.sv | 160 ++++++++++++++++
 tb/tb_uart_tx.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// 8N1 serial transmitter fed by a byte FIFO; drains write strobes from the
// memory-mapped TX register onto the board's RS-232 pin.
module uart_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 16,
  parameter int ADDR_W       = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clk_en,
  input  logic              wen,
  input  logic [7:0]        data,
  output logic              tx,
  output logic              busy,
  output logic              full,
  output logic [ADDR_W:0]   count,
  output logic              overflow
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0]   BIT_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [ADDR_W:0] DEPTH_C  = (ADDR_W + 1)'(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [7:0]        mem_q [FIFO_DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              ovf_q, ovf_d;
  logic [1:0]        state_q, state_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [2:0]        idx_q, idx_d;
  logic [7:0]        shift_q, shift_d;
  logic              tx_q, tx_d;
  logic              bit_end, pop, wr_req, push;

  assign bit_end = (timer_q == BIT_LAST);
  // A pop frees a slot on the same edge, so a full FIFO can still accept then.
  assign pop     = (count_q != '0) && ((state_q == S_IDLE) || ((state_q == S_STOP) && bit_end));
  assign wr_req  = wen && clk_en;
  assign push    = wr_req && ((count_q != DEPTH_C) || pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q | (wr_req && !push);
    if (push) begin
      wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + ADDR_W'(1);
    end
    if (push && !pop) begin
      count_d = count_q + (ADDR_W + 1)'(1);
    end else if (pop && !push) begin
      count_d = count_q - (ADDR_W + 1)'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    if (pop) begin
      state_d = S_START;
      timer_d = '0;
      shift_d = mem_q[rd_ptr_q];
      tx_d    = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          tx_d    = 1'b1;
          timer_d = '0;
        end
        S_START: begin
          if (bit_end) begin
            state_d = S_DATA;
            timer_d = '0;
            idx_d   = 3'd0;
            tx_d    = shift_q[0];
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
        S_DATA: begin
          if (bit_end) begin
            timer_d = '0;
            if (idx_q == 3'd7) begin
              state_d = S_STOP;
              tx_d    = 1'b1;
            end else begin
              idx_d   = idx_q + 3'd1;
              shift_d = {1'b0, shift_q[7:1]};
              tx_d    = shift_q[1];
            end
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
        S_STOP: begin
          if (bit_end) begin
            state_d = S_IDLE;
            timer_d = '0;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
        default: begin
          state_d = S_IDLE;
          timer_d = '0;
          tx_d    = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      state_q  <= S_IDLE;
      timer_q  <= '0;
      idx_q    <= '0;
      tx_q     <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      state_q  <= state_d;
      timer_q  <= timer_d;
      idx_q    <= idx_d;
      tx_q     <= tx_d;
    end
  end

  // Byte storage and shift register carry data only; control decides validity.
  always_ff @(posedge clk) begin
    shift_q <= shift_d;
    if (push) begin
      mem_q[wr_ptr_q] <= data;
    end
  end

  assign tx       = tx_q;
  assign busy     = (state_q != S_IDLE) || (count_q != '0);
  assign full     = (count_q == DEPTH_C);
  assign count    = count_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboarded bench for uart_tx: a frame-level reference model predicts FIFO
// contents and frame start edges; a line monitor decodes tx and compares.
module tb_uart_tx;
  localparam int CPB   = 4;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int FRAME = 10 * CPB;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          clk_en = 1'b0;
  logic          wen = 1'b0;
  logic [7:0]    data = 8'h00;
  logic          tx, busy, full, overflow;
  logic [AW:0]   count;

  uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .wen(wen), .data(data),
    .tx(tx), .busy(busy), .full(full), .count(count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] b;
    int         start;
  } frame_t;

  frame_t     sb_q[$];
  logic [7:0] mq[$];
  int         n = 0;
  int         fend = 0;
  bit         m_ovf = 1'b0;
  int         n_cmp = 0;
  int         n_bad = 0;

  task automatic check(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at edge %0d: got %0d, expected %0d", name, n - 1, act, exp);
    end
  endtask

  // Frame-level model: a byte leaves the queue whenever the line is free at an
  // edge (idle or previous frame just ended); each frame occupies FRAME edges.
  task automatic model_edge(bit w, bit ce, logic [7:0] d);
    bit     popped;
    frame_t f;
    popped = 1'b0;
    if (mq.size() > 0 && n >= fend) begin
      f.b     = mq.pop_front();
      f.start = n;
      sb_q.push_back(f);
      fend    = n + FRAME;
      popped  = 1'b1;
    end
    if (w && ce) begin
      if (popped || mq.size() < DEPTH) mq.push_back(d);
      else m_ovf = 1'b1;
    end
  endtask

  task automatic check_status();
    int e;
    e = n - 1;
    check("count", int'(count), mq.size());
    check("full", int'(full), int'(mq.size() == DEPTH));
    check("busy", int'(busy), int'((fend > e) || (mq.size() > 0)));
    check("overflow", int'(overflow), int'(m_ovf));
    if (!(fend > e)) check("idle_tx", int'(tx), 1);
  endtask

  task automatic step(bit w, bit ce, logic [7:0] d);
    @(negedge clk);
    wen = w; clk_en = ce; data = d;
    @(posedge clk);
    model_edge(w, ce, d);
    n++;
    #1;
    check_status();
  endtask

  task automatic do_reset();
    @(negedge clk);
    wen = 1'b0; clk_en = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("rst_tx", int'(tx), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_count", int'(count), 0);
    check("rst_full", int'(full), 0);
    check("rst_overflow", int'(overflow), 0);
    mq.delete();
    sb_q.delete();
    fend  = 0;
    m_ovf = 1'b0;
    repeat (2) begin
      @(posedge clk);
      n++;
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((mq.size() > 0 || fend > n - 1) && guard < 2000) begin
      step(1'b0, 1'b1, 8'h00);
      guard++;
    end
    check("drain_done", int'(guard < 2000), 1);
    repeat (3) step(1'b0, 1'b1, 8'h00);
  endtask

  // Line monitor: detects start bits, samples mid-bit, compares with scoreboard.
  initial begin : mon
    bit         act;
    bit         have_exp;
    int         st;
    int         rel;
    int         k;
    logic [7:0] got;
    frame_t     f;
    act = 1'b0;
    have_exp = 1'b0;
    st = 0;
    got = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        act = 1'b0;
      end else if (!act) begin
        if (tx == 1'b0) begin
          act = 1'b1;
          st  = n - 1;
          got = 8'h00;
          check("frame_expected", int'(sb_q.size() > 0), 1);
          have_exp = (sb_q.size() > 0);
          if (have_exp) begin
            f = sb_q.pop_front();
            check("frame_start_edge", st, f.start);
          end
        end
      end else begin
        rel = (n - 1) - st;
        if (rel % CPB == CPB / 2) begin
          k = rel / CPB;
          if (k == 0) check("start_bit", int'(tx), 0);
          else if (k <= 8) got[k-1] = tx;
          else begin
            check("stop_bit", int'(tx), 1);
            if (have_exp) check("frame_byte", int'(got), int'(f.b));
          end
        end
        if (rel == FRAME - 1) act = 1'b0;
      end
    end
  end

  initial begin : timeout
    #700000;
    $display("FAIL timeout: simulation exceeded its time budget");
    $fatal(1, "timeout");
  end

  initial begin : stim
    do_reset();
    repeat (2) step(1'b0, 1'b1, 8'h00);

    // Single byte.
    step(1'b1, 1'b1, 8'h55);
    drain();

    // Three back-to-back frames.
    step(1'b1, 1'b1, 8'h41);
    step(1'b1, 1'b1, 8'h42);
    step(1'b1, 1'b1, 8'h43);
    drain();

    // Writes masked by clk_en.
    repeat (10) step(1'b1, 1'b0, 8'hAA);
    check("masked_count", int'(count), 0);

    // Overfill: 18 writes on consecutive edges.
    for (int i = 0; i < 18; i++) step(1'b1, 1'b1, 8'(i));
    check("fill_full", int'(full), 1);
    check("fill_overflow", int'(overflow), 1);
    drain();

    // Reset mid-frame during data bit 3 with two bytes queued.
    step(1'b1, 1'b1, 8'h0F);
    step(1'b1, 1'b1, 8'h01);
    step(1'b1, 1'b1, 8'h02);
    while ((n - 1) < fend - FRAME + 4 * CPB + 1) step(1'b0, 1'b1, 8'h00);
    do_reset();
    step(1'b1, 1'b1, 8'h80);
    drain();

    // Write into a full FIFO on the edge where STOP ends and a pop happens.
    for (int i = 0; i < 17; i++) step(1'b1, 1'b1, 8'(8'hA0 + i));
    check("t6_full_before", int'(count), DEPTH);
    while (n < fend) step(1'b0, 1'b1, 8'h00);
    step(1'b1, 1'b1, 8'hC6);
    check("t6_count", int'(count), DEPTH);
    check("t6_overflow", int'(overflow), 0);
    drain();

    // Random traffic with bursts.
    for (int i = 0; i < 1500; i++) begin
      bit w;
      if ((i / 300) % 2 == 1) w = ($urandom_range(0, 3) != 0);
      else w = ($urandom_range(0, 11) == 0);
      step(w, ($urandom_range(0, 3) != 0), 8'($urandom));
    end
    drain();
    check("scoreboard_empty", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
